// File: rtl/epoch_dispatcher_pkg.sv
// Shared types and constants for the epoch dispatcher and its correlator-period defaults.
package epoch_dispatcher_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam int CORR_CTR_W = 12;
  localparam int DEF_PM1    = 2047;
endpackage

// File: rtl/epoch_dispatcher_ack_track.sv
// Per-channel dump tracker: remembers an unacknowledged strobe and flags a sticky overrun
// when a new strobe lands on it. Registered outputs, one cycle after the strobe/ack edge.
module dispatch_ack_track (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic stb,
  input  logic ack,
  input  logic ovr_clr,
  output logic overrun
);
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;

  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (clr)      pending_d = 1'b0;
    else if (stb) pending_d = 1'b1;
    else if (ack) pending_d = 1'b0;
    // A coincident ack retires the previous dump, so only an unacked pending one overruns.
    if (stb && pending_q && !ack) overrun_d = 1'b1;
    else if (ovr_clr)             overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
endmodule

// File: rtl/epoch_dispatcher.sv
// Epoch timer that clears the correlators each epoch and strobes dump requests round-robin
// to N_CH channels; continuous, burst and graceful-stop operation. All outputs registered.
module epoch_dispatcher #(
  parameter int CTR_W   = epoch_dispatcher_pkg::CORR_CTR_W,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int DEF_PM1 = epoch_dispatcher_pkg::DEF_PM1
) (
  input  logic                                    clk,
  input  logic                                    rst_in_n,
  input  logic                                    sync_clr,
  input  logic                                    start,
  input  logic                                    stop,
  input  logic                                    mode,
  input  logic [CNT_W-1:0]                        burst_len,
  input  logic                                    period_ld,
  input  logic [CTR_W-1:0]                        period_pm1,
  input  logic [N_CH-1:0]                         ch_ack,
  input  logic                                    ovr_clr,
  output logic                                    rst_out,
  output logic [N_CH-1:0]                         ch_stb,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_idx,
  output logic [CNT_W-1:0]                        epoch_cnt,
  output logic                                    busy,
  output logic [N_CH-1:0]                         overrun
);
  import epoch_dispatcher_pkg::*;

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [CTR_W-1:0]   pm1_q, pm1_d;
  logic [CTR_W-1:0]   shadow_q, shadow_d;
  logic               shadow_vld_q, shadow_vld_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [IDX_W-1:0]   ch_sel_q, ch_sel_d;
  logic [IDX_W-1:0]   ch_idx_q, ch_idx_d;
  logic [CNT_W-1:0]   epoch_cnt_q, epoch_cnt_d;
  logic               rst_out_q, rst_out_d;
  logic [N_CH-1:0]    ch_stb_q, ch_stb_d;
  logic               busy_q, busy_d;
  logic               boundary, last_burst;

  assign boundary   = (state_q != ST_IDLE) && (ctr_q == pm1_q);
  assign last_burst = mode_q && ((epoch_cnt_q + CNT_W'(1)) == burst_q);

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    pm1_d        = pm1_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    mode_d       = mode_q;
    burst_d      = burst_q;
    ch_sel_d     = ch_sel_q;
    ch_idx_d     = ch_idx_q;
    epoch_cnt_d  = epoch_cnt_q;
    rst_out_d    = 1'b0;
    ch_stb_d     = '0;
    if (sync_clr) begin
      state_d      = ST_IDLE;
      ctr_d        = '0;
      ch_sel_d     = '0;
      rst_out_d    = 1'b1;
    end else begin
      if (period_ld) begin
        shadow_d = period_pm1;
        if (state_q == ST_IDLE) pm1_d = period_pm1;
        else                    shadow_vld_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_RUN;
            ctr_d       = '0;
            mode_d      = mode;
            burst_d     = (burst_len == '0) ? CNT_W'(1) : burst_len;
            epoch_cnt_d = '0;
            rst_out_d   = 1'b1;
          end
        end
        ST_RUN, ST_STOP: begin
          ctr_d = ctr_q + CTR_W'(1);
          if (stop && state_q == ST_RUN) state_d = ST_STOP;
          if (boundary) begin
            ctr_d              = '0;
            rst_out_d          = 1'b1;
            ch_stb_d[ch_sel_q] = 1'b1;
            ch_idx_d           = ch_sel_q;
            ch_sel_d           = (ch_sel_q == IDX_W'(N_CH - 1)) ? '0 : ch_sel_q + IDX_W'(1);
            epoch_cnt_d        = epoch_cnt_q + CNT_W'(1);
            // A load in the boundary cycle itself is the latest one, so it takes effect now.
            if (period_ld) begin
              pm1_d        = period_pm1;
              shadow_vld_d = 1'b0;
            end else if (shadow_vld_q) begin
              pm1_d        = shadow_q;
              shadow_vld_d = 1'b0;
            end
            if (state_q == ST_STOP || last_burst) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q      <= ST_IDLE;
      ctr_q        <= '0;
      pm1_q        <= CTR_W'(DEF_PM1);
      shadow_q     <= CTR_W'(DEF_PM1);
      shadow_vld_q <= 1'b0;
      mode_q       <= 1'b0;
      burst_q      <= CNT_W'(1);
      ch_sel_q     <= '0;
      ch_idx_q     <= '0;
      epoch_cnt_q  <= '0;
      rst_out_q    <= 1'b0;
      ch_stb_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      pm1_q        <= pm1_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      mode_q       <= mode_d;
      burst_q      <= burst_d;
      ch_sel_q     <= ch_sel_d;
      ch_idx_q     <= ch_idx_d;
      epoch_cnt_q  <= epoch_cnt_d;
      rst_out_q    <= rst_out_d;
      ch_stb_q     <= ch_stb_d;
      busy_q       <= busy_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_trk
    dispatch_ack_track u_trk (
      .clk     (clk),
      .rst_n   (rst_in_n),
      .clr     (sync_clr),
      .stb     (ch_stb_q[i]),
      .ack     (ch_ack[i]),
      .ovr_clr (ovr_clr),
      .overrun (overrun[i])
    );
  end

  assign rst_out   = rst_out_q;
  assign ch_stb    = ch_stb_q;
  assign ch_idx    = ch_idx_q;
  assign epoch_cnt = epoch_cnt_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_epoch_dispatcher.sv
// Directed bench for epoch_dispatcher at default parameters (N_CH=4, 2048-cycle epochs).
module tb_epoch_dispatcher;
  logic        clk = 1'b0;
  logic        rst_in_n = 1'b1;
  logic        sync_clr = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [15:0] burst_len = '0;
  logic        period_ld = 1'b0;
  logic [11:0] period_pm1 = '0;
  logic [3:0]  ch_ack = '0;
  logic        ovr_clr = 1'b0;
  logic        rst_out;
  logic [3:0]  ch_stb;
  logic [1:0]  ch_idx;
  logic [15:0] epoch_cnt;
  logic        busy;
  logic [3:0]  overrun;
  logic [3:0]  ack_mask = 4'b1111;
  int          n_tests = 0;
  int          n_fail = 0;

  epoch_dispatcher dut (
    .clk(clk), .rst_in_n(rst_in_n), .sync_clr(sync_clr), .start(start), .stop(stop),
    .mode(mode), .burst_len(burst_len), .period_ld(period_ld), .period_pm1(period_pm1),
    .ch_ack(ch_ack), .ovr_clr(ovr_clr), .rst_out(rst_out), .ch_stb(ch_stb),
    .ch_idx(ch_idx), .epoch_cnt(epoch_cnt), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    {sync_clr, start, stop, mode, period_ld, ovr_clr} = '0;
    burst_len = '0; period_pm1 = '0; ch_ack = '0; ack_mask = 4'b1111;
    rst_in_n = 1'b0;
    step(); step();
    rst_in_n = 1'b1;
    step();
  endtask

  task automatic load_pm1(input logic [11:0] v);
    period_pm1 = v; period_ld = 1'b1;
    step();
    period_ld = 1'b0;
  endtask

  task automatic start_run(input logic m, input logic [15:0] bl);
    mode = m; burst_len = bl; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_pulse(output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (!rst_out && cyc < 5000);
  endtask

  task automatic run_cycle();
    step();
    ch_ack = ch_stb & ack_mask;
  endtask

  task automatic wait_stb(input int ch);
    int cyc = 0;
    do begin run_cycle(); cyc++; end while (!ch_stb[ch] && cyc < 100);
  endtask

  task automatic test_reset();
    #1 rst_in_n = 1'b0;
    #1;
    n_tests++; if ({rst_out, ch_stb, ch_idx, busy, overrun} !== 12'h000) begin n_fail++;
      $display("FAIL reset_outs: got %h exp 000", {rst_out, ch_stb, ch_idx, busy, overrun}); end
    n_tests++; if (epoch_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_epoch: got %0d exp 0", epoch_cnt); end
    step(); rst_in_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    n_tests++; if ({busy, rst_out, ch_stb} !== 6'b0) begin n_fail++;
      $display("FAIL idle_hold: got %b exp 000000", {busy, rst_out, ch_stb}); end
  endtask

  task automatic test_continuous();
    int c;
    logic [3:0] exp_stb;
    do_reset();
    start_run(1'b0, 16'd0);
    n_tests++; if ({rst_out, busy, ch_stb} !== 6'b110000) begin n_fail++;
      $display("FAIL start_pulse: got %b exp 110000", {rst_out, busy, ch_stb}); end
    for (int k = 1; k <= 5; k++) begin
      wait_pulse(c);
      exp_stb = 4'b0001 << ((k - 1) % 4);
      n_tests++; if (c !== 2048) begin n_fail++; $display("FAIL cont_gap%0d: got %0d exp 2048", k, c); end
      n_tests++; if (ch_stb !== exp_stb) begin n_fail++; $display("FAIL cont_stb%0d: got %b exp %b", k, ch_stb, exp_stb); end
      n_tests++; if (epoch_cnt !== 16'(k)) begin n_fail++; $display("FAIL cont_cnt%0d: got %0d exp %0d", k, epoch_cnt, k); end
    end
    n_tests++; if (ch_idx !== 2'd0) begin n_fail++; $display("FAIL cont_idx: got %0d exp 0", ch_idx); end
  endtask

  task automatic test_burst();
    int n, first_at, last_at;
    do_reset();
    load_pm1(12'd3);
    start_run(1'b1, 16'd3);
    n_tests++; if (ch_stb !== 4'b0000 || rst_out !== 1'b1) begin n_fail++;
      $display("FAIL burst_start: got stb %b rst %b exp 0000 1", ch_stb, rst_out); end
    n = 0; first_at = -1; last_at = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (ch_stb != 4'b0) begin n++; if (first_at < 0) first_at = c; last_at = c; end
    end
    n_tests++; if (n !== 3) begin n_fail++; $display("FAIL burst_n: got %0d exp 3", n); end
    n_tests++; if (first_at !== 4 || last_at !== 12) begin n_fail++;
      $display("FAIL burst_spacing: got first %0d last %0d exp 4 12", first_at, last_at); end
    n_tests++; if (busy !== 1'b0 || epoch_cnt !== 16'd3) begin n_fail++;
      $display("FAIL burst_end: got busy %b cnt %0d exp 0 3", busy, epoch_cnt); end
    start_run(1'b1, 16'd0);
    n = 0;
    for (int c = 1; c <= 20; c++) begin step(); if (ch_stb != 4'b0) n++; end
    n_tests++; if (n !== 1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL burst_zero: got n %0d busy %b exp 1 0", n, busy); end
  endtask

  task automatic test_period_shadow();
    int c;
    do_reset();
    start_run(1'b0, 16'd0);
    for (int i = 0; i < 100; i++) step();
    load_pm1(12'd9);
    wait_pulse(c);
    n_tests++; if (c + 101 !== 2048) begin n_fail++; $display("FAIL shadow_cur: got %0d exp 2048", c + 101); end
    wait_pulse(c);
    n_tests++; if (c !== 10) begin n_fail++; $display("FAIL shadow_next1: got %0d exp 10", c); end
    wait_pulse(c);
    n_tests++; if (c !== 10 || ch_stb !== 4'b0100) begin n_fail++;
      $display("FAIL shadow_next2: got %0d %b exp 10 0100", c, ch_stb); end
  endtask

  task automatic test_ack_overrun();
    do_reset();
    load_pm1(12'd3);
    ack_mask = 4'b1101;
    start_run(1'b0, 16'd0);
    wait_stb(1); run_cycle();
    n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_first: got %b exp 0000", overrun); end
    wait_stb(0); run_cycle();
    n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_coinc_ack: got %b exp 0000", overrun); end
    wait_stb(1); run_cycle();
    n_tests++; if (overrun !== 4'b0010) begin n_fail++; $display("FAIL ovr_second: got %b exp 0010", overrun); end
    ovr_clr = 1'b1; run_cycle(); ovr_clr = 1'b0;
    n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_clear: got %b exp 0000", overrun); end
    wait_stb(1); ovr_clr = 1'b1; run_cycle(); ovr_clr = 1'b0;
    n_tests++; if (overrun !== 4'b0010) begin n_fail++; $display("FAIL ovr_set_wins: got %b exp 0010", overrun); end
    ovr_clr = 1'b1; run_cycle(); ovr_clr = 1'b0;
    ch_ack = 4'b0010; step();
    wait_stb(1); run_cycle();
    n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_after_ack: got %b exp 0000", overrun); end
  endtask

  task automatic test_abort();
    int c;
    do_reset();
    load_pm1(12'd199);
    start_run(1'b0, 16'd0);
    wait_pulse(c);
    n_tests++; if (c !== 200 || epoch_cnt !== 16'd1) begin n_fail++;
      $display("FAIL abort_pre: got %0d cnt %0d exp 200 1", c, epoch_cnt); end
    for (int i = 0; i < 100; i++) step();
    sync_clr = 1'b1; step(); sync_clr = 1'b0;
    n_tests++; if ({rst_out, ch_stb, busy, ch_idx} !== 8'b1_0000_0_00) begin n_fail++;
      $display("FAIL abort_pulse: got %b exp 10000000", {rst_out, ch_stb, busy, ch_idx}); end
    for (int i = 0; i < 5; i++) step();
    n_tests++; if (epoch_cnt !== 16'd1 || rst_out !== 1'b0) begin n_fail++;
      $display("FAIL abort_hold: got cnt %0d rst %b exp 1 0", epoch_cnt, rst_out); end
    start_run(1'b0, 16'd0);
    wait_pulse(c);
    n_tests++; if (ch_stb !== 4'b0001) begin n_fail++; $display("FAIL abort_chsel: got %b exp 0001", ch_stb); end
    rst_in_n = 1'b0;
    #1;
    n_tests++; if ({rst_out, ch_stb, busy, ch_idx, overrun} !== 12'h000 || epoch_cnt !== 16'd0) begin n_fail++;
      $display("FAIL async_rst: got %b cnt %0d exp 0 0", {rst_out, ch_stb, busy, ch_idx, overrun}, epoch_cnt); end
    step(); rst_in_n = 1'b1; step();
  endtask

  task automatic test_stop();
    int c, n;
    do_reset();
    load_pm1(12'd15);
    start_run(1'b0, 16'd0);
    for (int i = 0; i < 5; i++) step();
    stop = 1'b1; step(); stop = 1'b0;
    c = 1;
    while (!rst_out && c < 100) begin step(); c++; end
    n_tests++; if (c !== 11 || ch_stb !== 4'b0001 || busy !== 1'b0) begin n_fail++;
      $display("FAIL stop_last: got %0d %b busy %b exp 11 0001 0", c, ch_stb, busy); end
    n = 0;
    for (int i = 0; i < 40; i++) begin step(); if (rst_out) n++; end
    n_tests++; if (n !== 0) begin n_fail++; $display("FAIL stop_idle: got %0d pulses exp 0", n); end
    stop = 1'b1; step(); stop = 1'b0; step();
    n_tests++; if (busy !== 1'b0 || rst_out !== 1'b0) begin n_fail++;
      $display("FAIL stop_in_idle: got busy %b rst %b exp 0 0", busy, rst_out); end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_tests++; if (busy !== 1'b1 || rst_out !== 1'b1) begin n_fail++;
      $display("FAIL start_stop: got busy %b rst %b exp 1 1", busy, rst_out); end
    for (int i = 0; i < 3; i++) step();
    start = 1'b1; step(); start = 1'b0;
    wait_pulse(c);
    n_tests++; if (c !== 12 || busy !== 1'b1 || ch_stb !== 4'b0010) begin n_fail++;
      $display("FAIL start_busy: got %0d busy %b %b exp 12 1 0010", c, busy, ch_stb); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_period_shadow();
    test_ack_overrun();
    test_abort();
    test_stop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/epoch_dispatcher.md
EPOCH_DISPATCHER -- requirements
Module: epoch_dispatcher

Interface
REQ-001 Parameter CTR_W, default 12: epoch counter and period width.
REQ-002 Parameter N_CH, default 4: number of correlator channels served round-robin, 1..16.
REQ-003 Parameter CNT_W, default 16: width of epoch count and burst length.
REQ-004 Parameter DEF_PM1, default 2047: reset value of period-minus-one, giving a 2048-cycle epoch.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_in_n  in  1  asynchronous, active-low reset.
- sync_clr  in  1  synchronous abort to IDLE.
- start  in  1  begin dispatching.
- stop  in  1  request graceful stop.
- mode  in  1  0 = continuous, 1 = burst.
- burst_len  in  CNT_W  epochs per burst; 0 is treated as 1.
- period_ld  in  1  load period_pm1.
- period_pm1  in  CTR_W  epoch length minus one.
- ch_ack  in  N_CH  consumer dump acknowledge.
- ovr_clr  in  1  clear overrun flags.
- rst_out  out  1  one-cycle correlator clear pulse at each epoch start.
- ch_stb  out  N_CH  one-hot dump strobe to the selected channel.
- ch_idx  out  clog2(N_CH), min 1  index of the last strobed channel.
- epoch_cnt  out  CNT_W  epochs completed since start, wraps.
- busy  out  1  high when state is not IDLE.
- overrun  out  N_CH  sticky: strobe issued while the previous one is unacked.

Function
REQ-006 States are IDLE, RUN and STOP; busy is 1 in RUN and STOP.
REQ-007 IDLE with start=1 SHALL go to RUN, zero ctr, latch mode and burst_len, and pulse rst_out on the next cycle with no ch_stb.
REQ-008 In RUN/STOP, ctr SHALL increment each cycle; the boundary is the cycle where ctr==pm1_active.
- ctr becomes 0 on the next cycle.
- pm1_active=0 gives a boundary every cycle.
REQ-009 At a boundary the following outputs SHALL be registered and high for exactly the one cycle in which ctr==0:
- rst_out=1.
- ch_stb[ch_sel]=1.
- ch_idx=ch_sel.
- ch_sel advances modulo N_CH.
- epoch_cnt increments, wrapping at 2^CNT_W.
REQ-010 period_ld in IDLE SHALL update pm1_active on the next cycle; in RUN/STOP it loads a shadow register applied at the next boundary, with the last load winning.
REQ-011 Burst mode: at the boundary completing the burst_len-th epoch, the FSM SHALL issue the strobe and then enter IDLE.
REQ-012 stop in RUN SHALL enter STOP; STOP issues the strobe at the next boundary, then enters IDLE. stop in STOP or IDLE SHALL be ignored.
REQ-013 start while busy SHALL be ignored.
REQ-014 start and stop asserted together in IDLE SHALL act as start only.
REQ-015 sync_clr (priority over all other inputs) SHALL, on the next cycle:
- force IDLE, with ctr=0 and ch_sel=0;
- pulse rst_out with no ch_stb;
- clear pending;
- preserve overrun and epoch_cnt.
REQ-016 Per channel, pending[i] SHALL be set on ch_stb[i] and cleared on ch_ack[i].
- Strobe with pending already set and no same-cycle ack: overrun[i] set.
- Strobe and ack in the same cycle: pending stays 1, no overrun.
REQ-017 ovr_clr SHALL clear all overrun bits; if a set condition coincides, set wins.
REQ-018 Outputs SHALL be driven only from flops.

Reset
REQ-019 When rst_in_n=0, all state SHALL clear asynchronously:
- state=IDLE, ctr=0, ch_sel=0, ch_idx=0, epoch_cnt=0;
- pending=0, overrun=0;
- rst_out=0, ch_stb=0, busy=0;
- pm1_active and shadow = DEF_PM1.
REQ-020 Deassertion SHALL be synchronised externally; the block SHALL make no transition until start arrives.

Structure
REQ-021 A shared package SHALL hold the state enum and DEF_PM1, alongside the correlator period constants.
REQ-022 The per-channel pending/overrun tracker SHALL be one sub-module, dispatch_ack_track, instantiated N_CH times.

Verification
REQ-023 Defaults with start and continuous mode: rst_out SHALL pulse 2048 cycles apart; ch_stb SHALL cycle 0001, 0010, 0100, 1000, 0001; epoch_cnt SHALL be 1..5.
REQ-024 period_pm1=3 loaded in IDLE, mode=1, burst_len=3: SHALL give exactly 3 strobes 4 cycles apart, then busy=0; burst_len=0 SHALL give exactly 1 strobe.
REQ-025 period_ld=9 mid-epoch at period 2048: the current epoch SHALL complete at 2048 cycles and the following epochs SHALL be 10 cycles.
REQ-026 Ack boundaries with ch_ack withheld on channel 1:
- the second strobe to channel 1 SHALL set overrun[1];
- an ack coincident with the strobe SHALL not set it;
- ovr_clr coincident with a set SHALL leave it set.
REQ-027 Reset and abort mid-epoch (ctr=100):
- sync_clr SHALL yield rst_out pulse, IDLE, ch_sel=0, with epoch_cnt held;
- rst_in_n low mid-epoch SHALL clear all outputs immediately, without a clock edge.
REQ-028 stop at ctr=5 with period 16: the last strobe SHALL occur at the boundary 11 cycles later, followed by IDLE; stop in IDLE SHALL have no effect.
